// File: rtl/hash_stream_master.sv
// Host-side initiator for the hash-table stream interface.
// It packs each host command into a request word and sends it to the table through a
// one-entry request register. A credit counter tracks requests that have no response yet,
// and new commands are throttled so the response FIFO can never overflow.
module hash_stream_master #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned KEY_WIDTH       = 30,
    parameter int unsigned VALUE_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned OW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned AW             = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_i,
    input  logic [VALUE_WIDTH-1:0] cmd_value_i,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [DATA_WIDTH-1:0]  tx_data_o,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    input  logic [DATA_WIDTH-1:0]  rx_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_WIDTH-1:0]  rsp_data_o,
    output logic [OW-1:0]          outstanding_o,
    output logic                   idle_o,
    output logic                   err_unexp_o
);

    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [OW-1:0]         r_outstanding;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;

    logic w_full;
    logic w_empty;
    logic w_credit_ok;
    logic w_cmd_acc;
    logic w_tx_hs;
    logic w_rx_hs;
    logic w_pop;

    // Handshake and status decode from registered state and current inputs
    always_comb begin
        w_full      = (r_count == (AW + 1)'(FIFO_DEPTH));
        w_empty     = (r_count == '0);
        // A word still sitting in the request register already holds a credit
        w_credit_ok = (32'(r_outstanding) + 32'(r_tx_valid)) < MAX_OUTSTANDING;
        cmd_ready_o = reset & (~r_tx_valid | tx_ready_i) & w_credit_ok;
        rx_ready_o  = reset & ~w_full;
        w_cmd_acc   = cmd_valid_i & cmd_ready_o;
        w_tx_hs     = r_tx_valid & tx_ready_i;
        w_rx_hs     = rx_valid_i & rx_ready_o;
        w_pop       = ~w_empty & rsp_ready_i;
    end

    // Request register: load on accept, clear on send, otherwise hold stable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_cmd_acc) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= {cmd_op_i, cmd_key_i, cmd_value_i};
        end else if (w_tx_hs) begin
            r_tx_valid <= 1'b0;
        end
    end

    // Credit counter and sticky unexpected-response flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_tx_hs && !w_rx_hs) begin
                r_outstanding <= r_outstanding + OW'(1);
            end else if (w_rx_hs && !w_tx_hs && (r_outstanding != '0)) begin
                r_outstanding <= r_outstanding - OW'(1);
            end
            // The word is still stored; only the flag records the protocol slip
            if (w_rx_hs && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Response FIFO storage; contents need no reset because the output is gated by empty
    always_ff @(posedge clk) begin
        if (w_rx_hs) begin
            r_mem[r_wptr] <= rx_data_i;
        end
    end

    // Response FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_rx_hs) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_rx_hs && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_rx_hs) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    // Output mapping
    always_comb begin
        tx_valid_o    = r_tx_valid;
        tx_data_o     = r_tx_data;
        rsp_valid_o   = ~w_empty;
        rsp_data_o    = w_empty ? '0 : r_mem[r_rptr];
        outstanding_o = r_outstanding;
        err_unexp_o   = r_err;
        idle_o        = ~r_tx_valid & (r_outstanding == '0) & w_empty;
    end

endmodule
